// File: rtl/add_share_pkg.sv
`default_nettype none
// ============================================================================
// Package  : add_share_pkg
// Brief    : Shared types and helpers for the two-requester shared adder.
// Revision : 1.0 - initial release
// ============================================================================
package add_share_pkg;

    // Requester tag carried down the adder pipeline.
    typedef logic [0:0] req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    // The sum keeps the carry in its MSB.
    function automatic int SUM_W(input int data_w);
        return data_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/add_share_fifo.sv
`default_nettype none
// ============================================================================
// Module   : add_share_fifo
// Brief    : First-word-fall-through synchronous FIFO with occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module add_share_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_empty,
    output logic             o_full,
    output logic [CNT_W-1:0] o_count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_wr;
    logic               w_rd;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign w_rd = i_rd_en && !o_empty;
    assign w_wr = i_wr_en && (!o_full || w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_wr && !w_rd) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr && w_rd) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/add_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : add_share_arbiter
// Brief    : Round-robin, credit-flow-controlled sharing of one pipelined adder.
// Revision : 1.0 - initial release
// ============================================================================
module add_share_arbiter
    import add_share_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADD_LAT    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    input  logic              r0_valid,
    output logic              r0_ready,
    output logic [DATA_W:0]   r0_sum,
    output logic              r0_sum_valid,
    input  logic              r0_sum_ready,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    input  logic              r1_valid,
    output logic              r1_ready,
    output logic [DATA_W:0]   r1_sum,
    output logic              r1_sum_valid,
    input  logic              r1_sum_ready
);

    localparam int c_SUM_W = SUM_W(DATA_W);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_USE_W = c_CNT_W + 1;

    typedef struct packed {
        logic               valid;
        req_id_t            tag;
        logic [c_SUM_W-1:0] sum;
    } pipe_entry_t;

    logic [1:0]                w_valid;
    logic [1:0]                w_sum_ready;
    logic [1:0]                w_elig;
    logic [1:0]                w_grant;
    logic [1:0]                w_fifo_wr;
    logic [1:0]                w_fifo_empty;
    logic [1:0][c_SUM_W-1:0]   w_fifo_data;
    req_id_t                   r_last_grant;
    pipe_entry_t               r_pipe [ADD_LAT];
    pipe_entry_t               w_issue;
    pipe_entry_t               w_exit;

    assign w_valid     = {r1_valid, r0_valid};
    assign w_sum_ready = {r1_sum_ready, r0_sum_ready};

    // ------------------------------------------------------------------
    // Per-requester credit accounting and response buffering
    // ------------------------------------------------------------------
    for (genvar n = 0; n < 2; n++) begin : g_req
        logic [c_CNT_W-1:0] r_inflight;
        logic [c_CNT_W-1:0] w_fifo_count;
        logic [c_USE_W-1:0] w_used;
        logic               w_fifo_full;

        // A slot is committed from issue until the consumer pops the result.
        assign w_used    = {1'b0, w_fifo_count} + {1'b0, r_inflight};
        assign w_elig[n] = !rst && w_valid[n] && (w_used < c_USE_W'(FIFO_DEPTH));
        assign w_fifo_wr[n] = w_exit.valid && (w_exit.tag == req_id_t'(n));

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_inflight <= '0;
            end else if (w_grant[n] && !w_fifo_wr[n]) begin
                r_inflight <= r_inflight + 1'b1;
            end else if (!w_grant[n] && w_fifo_wr[n]) begin
                r_inflight <= r_inflight - 1'b1;
            end
        end

        add_share_fifo #(
            .WIDTH (c_SUM_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .i_wr_en   (w_fifo_wr[n]),
            .i_wr_data (w_exit.sum),
            .i_rd_en   (w_sum_ready[n]),
            .o_rd_data (w_fifo_data[n]),
            .o_empty   (w_fifo_empty[n]),
            .o_full    (w_fifo_full),
            .o_count   (w_fifo_count)
        );

        a_no_overflow : assert property (@(posedge clk) disable iff (rst)
            !(w_fifo_wr[n] && w_fifo_full && !w_sum_ready[n]));
    end

    // ------------------------------------------------------------------
    // Round-robin arbitration: on a tie the requester not granted last wins
    // ------------------------------------------------------------------
    always_comb begin
        w_grant = 2'b00;
        if (w_elig[0] && (!w_elig[1] || (r_last_grant == REQ1))) begin
            w_grant[0] = 1'b1;
        end else if (w_elig[1]) begin
            w_grant[1] = 1'b1;
        end
    end

    always_comb begin
        w_issue       = '0;
        w_issue.valid = |w_grant;
        w_issue.tag   = w_grant[1] ? REQ1 : REQ0;
        w_issue.sum   = w_grant[1] ? (c_SUM_W'(r1_a) + c_SUM_W'(r1_b))
                                   : (c_SUM_W'(r0_a) + c_SUM_W'(r0_b));
    end

    // ------------------------------------------------------------------
    // Adder pipeline: never stalls, credits guarantee room at the exit
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < ADD_LAT; k++) begin
                r_pipe[k] <= '0;
            end
            r_last_grant <= REQ1;
        end else begin
            r_pipe[0] <= w_issue;
            for (int k = 1; k < ADD_LAT; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
            if (|w_grant) begin
                r_last_grant <= w_grant[1] ? REQ1 : REQ0;
            end
        end
    end

    assign w_exit = r_pipe[ADD_LAT-1];

    assign r0_ready     = w_grant[0];
    assign r1_ready     = w_grant[1];
    assign r0_sum_valid = !w_fifo_empty[0];
    assign r1_sum_valid = !w_fifo_empty[1];
    assign r0_sum       = w_fifo_empty[0] ? '0 : w_fifo_data[0];
    assign r1_sum       = w_fifo_empty[1] ? '0 : w_fifo_data[1];

endmodule
`default_nettype wire
